// File: rtl/mips31_pkg.sv
// Shared MIPS31 definitions: phase encoding, instruction class indices and PC source selects.
package mips31_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } state_e;

  localparam int unsigned InstrJr  = 16;
  localparam int unsigned InstrLw  = 23;
  localparam int unsigned InstrSw  = 24;
  localparam int unsigned InstrBeq = 25;
  localparam int unsigned InstrBne = 26;
  localparam int unsigned InstrJ   = 29;
  localparam int unsigned InstrJal = 30;

  localparam logic [1:0] PcSelSeq    = 2'd0;
  localparam logic [1:0] PcSelBranch = 2'd1;
  localparam logic [1:0] PcSelJump   = 2'd2;
  localparam logic [1:0] PcSelReg    = 2'd3;

  // True when exactly one bit of v is set.
  function automatic logic is_one_hot(input logic [31:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Enable counter with asynchronous active-low clear; wraps modulo 2^CNT_W.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer gating datapath write strobes and
// counting retired instructions.
module multicycle_sequencer
  import mips31_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction_type,
  input  logic             z,
  input  logic             im_ready,
  input  logic             dm_ready,
  output logic             IM_R,
  output logic             IR_W,
  output logic             PC_W,
  output logic [1:0]       pc_sel,
  output logic             RF_W,
  output logic             DM_CS,
  output logic             DM_R,
  output logic             DM_W,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e state_q, state_d;

  logic is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic br_taken;

  assign is_jr    = instruction_type[InstrJr];
  assign is_lw    = instruction_type[InstrLw];
  assign is_sw    = instruction_type[InstrSw];
  assign is_beq   = instruction_type[InstrBeq];
  assign is_bne   = instruction_type[InstrBne];
  assign is_j     = instruction_type[InstrJ];
  assign is_jal   = instruction_type[InstrJal];
  assign br_taken = (is_beq & z) | (is_bne & ~z);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // Strobes are qualified with rst_n so an asserted reset silences them immediately.
  always_comb begin
    state_d = state_q;
    IM_R    = 1'b0;
    IR_W    = 1'b0;
    PC_W    = 1'b0;
    pc_sel  = PcSelSeq;
    RF_W    = 1'b0;
    DM_CS   = 1'b0;
    DM_R    = 1'b0;
    DM_W    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          IM_R = 1'b1;
          if (im_ready) begin
            IR_W    = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: begin
          state_d = is_one_hot(instruction_type) ? StExec : StTrap;
        end
        StExec: begin
          if (is_beq || is_bne) begin
            PC_W    = 1'b1;
            pc_sel  = br_taken ? PcSelBranch : PcSelSeq;
            state_d = StFetch;
          end else if (is_j) begin
            PC_W    = 1'b1;
            pc_sel  = PcSelJump;
            state_d = StFetch;
          end else if (is_jr) begin
            PC_W    = 1'b1;
            pc_sel  = PcSelReg;
            state_d = StFetch;
          end else if (is_lw || is_sw) begin
            state_d = StMem;
          end else begin
            state_d = StWb;
          end
        end
        StMem: begin
          DM_CS = 1'b1;
          DM_R  = is_lw;
          DM_W  = is_sw;
          if (dm_ready) begin
            if (is_sw) begin
              PC_W    = 1'b1;
              state_d = StFetch;
            end else begin
              state_d = StWb;
            end
          end
        end
        StWb: begin
          RF_W    = 1'b1;
          PC_W    = 1'b1;
          pc_sel  = is_jal ? PcSelJump : PcSelSeq;
          state_d = StFetch;
        end
        StTrap: begin
          state_d = StTrap;
        end
        default: begin
          state_d = StTrap;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = (state_q == StTrap);

  retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (PC_W),
    .cnt_o (retire_cnt)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs from a phase-level model,
// a negedge monitor pops and compares against the DUT.
module tb_multicycle_sequencer;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic [31:0]   instruction_type;
  logic          z, im_ready, dm_ready;
  logic          IM_R, IR_W, PC_W, RF_W, DM_CS, DM_R, DM_W, illegal;
  logic [1:0]    pc_sel;
  logic [2:0]    state;
  logic [CW-1:0] retire_cnt;

  multicycle_sequencer #(
    .CNT_W(CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instruction_type(instruction_type),
    .z               (z),
    .im_ready        (im_ready),
    .dm_ready        (dm_ready),
    .IM_R            (IM_R),
    .IR_W            (IR_W),
    .PC_W            (PC_W),
    .pc_sel          (pc_sel),
    .RF_W            (RF_W),
    .DM_CS           (DM_CS),
    .DM_R            (DM_R),
    .DM_W            (DM_W),
    .state           (state),
    .illegal         (illegal),
    .retire_cnt      (retire_cnt)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic          ill;
    logic          im_r;
    logic          ir_w;
    logic          pc_w;
    logic [1:0]    sel;
    logic          rf_w;
    logic          cs;
    logic          rd;
    logic          wr;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   model_cnt = 0;
  int   cyc_no = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  function automatic string fmt(input exp_t e);
    return $sformatf("st=%0d ill=%b imr=%b irw=%b pcw=%b sel=%0d rfw=%b cs=%b r=%b w=%b cnt=%0d",
                     e.st, e.ill, e.im_r, e.ir_w, e.pc_w, e.sel, e.rf_w, e.cs, e.rd, e.wr, e.cnt);
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    cyc_no++;
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      a.st   = state;
      a.ill  = illegal;
      a.im_r = IM_R;
      a.ir_w = IR_W;
      a.pc_w = PC_W;
      a.sel  = PC_W ? pc_sel : 2'd0;
      a.rf_w = RF_W;
      a.cs   = DM_CS;
      a.rd   = DM_R;
      a.wr   = DM_W;
      a.cnt  = retire_cnt;
      checks++;
      if (a === e) passes++;
      else $display("FAIL cycle%0d outputs: got {%s} required {%s}", cyc_no, fmt(a), fmt(e));
    end
  end

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  // Record the expected outputs of the current cycle, then advance one clock.
  task automatic cyc(input exp_t e);
    e.cnt = CW'(model_cnt);
    sb.push_back(e);
    if (e.pc_w) model_cnt = (model_cnt + 1) % (1 << CW);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_inputs();
    z        = 1'($urandom);
    im_ready = 1'($urandom);
    dm_ready = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < n; i++) begin
      rnd_inputs();
      instruction_type = $urandom;
      cyc(blank(3'd0));
    end
    rst_n = 1'b1;
  endtask

  // One instruction through the phases; abort_mem stops after the first MEM cycle.
  task automatic issue(input logic [31:0] it, input logic zv, input int imw, input int dmw,
                       input bit abort_mem);
    exp_t e;
    bit   lw, sw, br, jmp, jr, jal;
    lw  = it[23];
    sw  = it[24];
    br  = it[25] | it[26];
    jmp = it[29];
    jr  = it[16];
    jal = it[30];
    for (int i = 0; i <= imw; i++) begin
      rnd_inputs();
      im_ready         = (i == imw);
      instruction_type = $urandom;
      e = blank(3'd0);
      e.im_r = 1'b1;
      e.ir_w = (i == imw);
      cyc(e);
    end
    instruction_type = it;
    rnd_inputs();
    cyc(blank(3'd1));
    if ($countones(it) != 1) begin
      for (int i = 0; i < 3; i++) begin
        rnd_inputs();
        e     = blank(3'd7);
        e.ill = 1'b1;
        cyc(e);
      end
      return;
    end
    rnd_inputs();
    z = zv;
    e = blank(3'd2);
    if (br) begin
      e.pc_w = 1'b1;
      e.sel  = ((it[25] && zv) || (it[26] && !zv)) ? 2'd1 : 2'd0;
    end else if (jmp) begin
      e.pc_w = 1'b1;
      e.sel  = 2'd2;
    end else if (jr) begin
      e.pc_w = 1'b1;
      e.sel  = 2'd3;
    end
    cyc(e);
    if (br || jmp || jr) return;
    if (lw || sw) begin
      for (int i = 0; i <= dmw; i++) begin
        if (abort_mem && i == 1) return;
        rnd_inputs();
        dm_ready = (i == dmw);
        e      = blank(3'd3);
        e.cs   = 1'b1;
        e.rd   = lw;
        e.wr   = sw;
        e.pc_w = sw && (i == dmw);
        cyc(e);
      end
      if (sw) return;
    end
    rnd_inputs();
    e      = blank(3'd4);
    e.rf_w = 1'b1;
    e.pc_w = 1'b1;
    e.sel  = jal ? 2'd2 : 2'd0;
    cyc(e);
  endtask

  initial begin
    logic [31:0] it;
    rst_n            = 1'b0;
    instruction_type = '0;
    z                = 1'b0;
    im_ready         = 1'b0;
    dm_ready         = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    issue(32'h1, 1'($urandom), 0, 0, 1'b0);
    issue(32'h1 << 25, 1'b1, 0, 0, 1'b0);
    issue(32'h1 << 25, 1'b0, 0, 0, 1'b0);
    issue(32'h1 << 26, 1'b0, 1, 0, 1'b0);
    issue(32'h1 << 23, 1'($urandom), 0, 3, 1'b0);
    issue(32'h1 << 24, 1'($urandom), 0, 0, 1'b0);
    issue(32'h1 << 30, 1'($urandom), 0, 0, 1'b0);
    issue(32'h1 << 29, 1'($urandom), 2, 0, 1'b0);
    issue(32'h1 << 16, 1'($urandom), 0, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      it = 32'h1 << $urandom_range(31, 0);
      if (n % 4 == 0) it = 32'h1 << (($urandom_range(1, 0) == 1) ? 23 : 24);
      issue(it, 1'($urandom), $urandom_range(2, 0), $urandom_range(2, 0), 1'b0);
    end

    issue(32'h0, 1'($urandom), 0, 0, 1'b0);
    do_reset(2);
    issue(32'h1 << 5, 1'($urandom), 0, 0, 1'b0);
    issue((32'h1 << 23) | (32'h1 << 24), 1'($urandom), 1, 0, 1'b0);
    do_reset(1);
    issue(32'h1 << 25, 1'b1, 0, 0, 1'b0);

    issue(32'h1 << 24, 1'($urandom), 0, 5, 1'b1);
    do_reset(2);
    issue(32'h1 << 7, 1'($urandom), 0, 0, 1'b0);
    issue(32'h1 << 24, 1'($urandom), 1, 1, 1'b0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
